// File: rtl/fft_peak_pkg.sv
// Shared definitions for the FFT peak tracker: FSM encoding, default note table
// and the widening absolute-value helper used by the magnitude datapath.
package fft_peak_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_RE,
      S_RD_IM,
      S_CMP,
      S_NOTE,
      S_FIN
   } state_t;

   localparam int DEFAULT_N_NOTES = 6;
   localparam int DEFAULT_BIN_W   = 10;

   // Entry 0 sits in the low bits: 165, 110, 147, 196, 247, 330.
   localparam logic [DEFAULT_N_NOTES*DEFAULT_BIN_W-1:0] DEFAULT_NOTE_TABLE =
      {10'd330, 10'd247, 10'd196, 10'd147, 10'd110, 10'd165};

   // Caller sign-extends into 32 bits first, so the most negative sample negates cleanly.
   function automatic logic [31:0] abs_ext(input logic signed [31:0] v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/fft_peak_tracker_nearest_note.sv
// Sequential nearest-note search: walks the note table one entry per cycle and
// keeps the closest entry (lowest index wins ties) plus its signed bin offset.
module nearest_note #(
   parameter int N_NOTES = 6,
   parameter int BIN_W   = 10,
   parameter int NOTE_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_start,
   input  logic                     i_abort,
   input  logic [N_NOTES*BIN_W-1:0] i_table,
   input  logic [BIN_W-1:0]         i_bin,
   output logic                     o_last,
   output logic [NOTE_W-1:0]        o_note,
   output logic signed [BIN_W:0]    o_diff
);

   logic [BIN_W-1:0]      w_entry [N_NOTES];
   logic signed [BIN_W:0] w_diff;
   logic [BIN_W:0]        w_dist;
   logic                  r_run;
   logic [NOTE_W-1:0]     r_k;
   logic [BIN_W:0]        r_min;
   logic [NOTE_W-1:0]     r_note;
   logic signed [BIN_W:0] r_diff;

   genvar gi;
   generate
      for (gi = 0; gi < N_NOTES; gi++) begin : g_entry
         assign w_entry[gi] = i_table[gi*BIN_W +: BIN_W];
      end
   endgenerate

   assign w_diff = $signed({1'b0, w_entry[r_k]}) - $signed({1'b0, i_bin});
   assign w_dist = (w_diff < 0) ? -w_diff : w_diff;
   assign o_last = r_run && (r_k == NOTE_W'(N_NOTES - 1));
   assign o_note = r_note;
   assign o_diff = r_diff;

   // Running minimum starts at all-ones, above any reachable distance, so entry 0 always seeds it.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_run  <= 1'b0;
         r_k    <= '0;
         r_min  <= '1;
         r_note <= '0;
         r_diff <= '0;
      end else if (i_abort) begin
         r_run <= 1'b0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_k   <= '0;
         r_min <= '1;
      end else if (r_run) begin
         if (w_dist < r_min) begin
            r_min  <= w_dist;
            r_note <= r_k;
            r_diff <= w_diff;
         end
         if (o_last) r_run <= 1'b0;
         else        r_k   <= r_k + 1'b1;
      end
   end

endmodule

// File: rtl/fft_peak_tracker.sv
// Scans a bin window of a split re/im FFT memory, tracks the largest |re|+|im|,
// gates it against a threshold and reports the nearest note-table entry.
module fft_peak_tracker
   import fft_peak_pkg::*;
#(
   parameter int DATA_W    = 10,
   parameter int ADDR_W    = 11,
   parameter int IM_OFFSET = 1024,
   parameter int BIN_LO    = 20,
   parameter int BIN_HI    = 511,
   parameter int BIN_W     = 10,
   parameter int N_NOTES   = 6,
   parameter int MEM_LAT   = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic [DATA_W:0]              mag_thresh,
   input  logic [N_NOTES*BIN_W-1:0]     note_table,
   input  logic signed [DATA_W-1:0]     data_in,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic                         busy,
   output logic                         done,
   output logic                         valid,
   output logic [BIN_W-1:0]             peak_bin,
   output logic [DATA_W:0]              peak_mag,
   output logic [$clog2(N_NOTES)-1:0]   note,
   output logic signed [BIN_W:0]        difference
);

   localparam int NOTE_W = $clog2(N_NOTES);
   localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int MAG_W  = DATA_W + 1;

   state_t                   r_state;
   logic [BIN_W-1:0]         r_bin, r_best_bin, r_peak_bin;
   logic [WAIT_W-1:0]        r_wait;
   logic signed [DATA_W-1:0] r_re, r_im;
   logic [MAG_W-1:0]         r_best_mag, r_peak_mag;
   logic [ADDR_W-1:0]        r_mem_addr;
   logic                     r_busy, r_done, r_valid;
   logic [NOTE_W-1:0]        r_note;
   logic signed [BIN_W:0]    r_diff;

   logic [MAG_W-1:0]         w_mag;
   logic                     w_wait_done, w_last_bin, w_nn_start, w_nn_last;
   logic [NOTE_W-1:0]        w_nn_note;
   logic signed [BIN_W:0]    w_nn_diff;

   assign w_mag       = MAG_W'(abs_ext(32'(r_re))) + MAG_W'(abs_ext(32'(r_im)));
   assign w_wait_done = (r_wait == WAIT_W'(MEM_LAT - 1));
   assign w_last_bin  = (r_bin == BIN_W'(BIN_HI));
   assign w_nn_start  = (r_state == S_CMP) && w_last_bin && !abort;

   nearest_note #(
      .N_NOTES (N_NOTES),
      .BIN_W   (BIN_W),
      .NOTE_W  (NOTE_W)
   ) u_nearest_note (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_nn_start),
      .i_abort (abort),
      .i_table (note_table),
      .i_bin   (r_best_bin),
      .o_last  (w_nn_last),
      .o_note  (w_nn_note),
      .o_diff  (w_nn_diff)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state    <= S_IDLE;
         r_bin      <= '0;
         r_best_bin <= '0;
         r_best_mag <= '0;
         r_wait     <= '0;
         r_re       <= '0;
         r_im       <= '0;
         r_mem_addr <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_valid    <= 1'b0;
         r_peak_bin <= '0;
         r_peak_mag <= '0;
         r_note     <= '0;
         r_diff     <= '0;
      end else begin
         r_done <= 1'b0;
         if (abort && r_state != S_IDLE) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: if (start && !abort) begin
                  r_mem_addr <= ADDR_W'(BIN_LO);
                  r_bin      <= BIN_W'(BIN_LO);
                  r_best_bin <= BIN_W'(BIN_LO);
                  r_best_mag <= '0;
                  r_wait     <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_RD_RE;
               end
               S_RD_RE: if (w_wait_done) begin
                  r_re       <= data_in;
                  r_mem_addr <= ADDR_W'(r_bin) + ADDR_W'(IM_OFFSET);
                  r_wait     <= '0;
                  r_state    <= S_RD_IM;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
               S_RD_IM: if (w_wait_done) begin
                  r_im    <= data_in;
                  r_wait  <= '0;
                  r_state <= S_CMP;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
               S_CMP: begin
                  // Strict compare keeps the lowest bin on equal magnitudes.
                  if (w_mag > r_best_mag) begin
                     r_best_mag <= w_mag;
                     r_best_bin <= r_bin;
                  end
                  if (w_last_bin) begin
                     r_state <= S_NOTE;
                  end else begin
                     r_bin      <= r_bin + 1'b1;
                     r_mem_addr <= ADDR_W'(r_bin) + 1'b1;
                     r_state    <= S_RD_RE;
                  end
               end
               S_NOTE: if (w_nn_last) r_state <= S_FIN;
               S_FIN: begin
                  r_peak_bin <= r_best_bin;
                  r_peak_mag <= r_best_mag;
                  if (r_best_mag >= mag_thresh) begin
                     r_valid <= 1'b1;
                     r_note  <= w_nn_note;
                     r_diff  <= w_nn_diff;
                  end else begin
                     r_valid <= 1'b0;
                     r_note  <= '0;
                     r_diff  <= '0;
                  end
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign mem_addr   = r_mem_addr;
   assign busy       = r_busy;
   assign done       = r_done;
   assign valid      = r_valid;
   assign peak_bin   = r_peak_bin;
   assign peak_mag   = r_peak_mag;
   assign note       = r_note;
   assign difference = r_diff;

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Directed bench for fft_peak_tracker: behavioural reference model, per-cycle
// output compare on the falling edge, and literal pins for key scenarios.
module tb_fft_peak_tracker;
   import fft_peak_pkg::*;

   localparam int DATA_W    = 10;
   localparam int ADDR_W    = 11;
   localparam int IM_OFFSET = 1024;
   localparam int BIN_LO    = 4;
   localparam int BIN_HI    = 11;
   localparam int BIN_W     = 10;
   localparam int N_NOTES   = 6;
   localparam int MEM_LAT   = 1;
   localparam int NOTE_W    = $clog2(N_NOTES);
   localparam int LAT       = (BIN_HI - BIN_LO + 1) * (2 * MEM_LAT + 1) + N_NOTES + 1;

   logic                     clk = 1'b0;
   logic                     rst_n, start, abort;
   logic [DATA_W:0]          mag_thresh;
   logic [N_NOTES*BIN_W-1:0] note_table;
   logic [DATA_W-1:0]        data_in;
   logic [ADDR_W-1:0]        mem_addr;
   logic                     busy, done, valid;
   logic [BIN_W-1:0]         peak_bin;
   logic [DATA_W:0]          peak_mag;
   logic [NOTE_W-1:0]        note;
   logic [BIN_W:0]           difference;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   int   n_cmp = 0, n_err = 0;
   logic cmp_en = 1'b0;
   int   exp_busy = 0, exp_done = 0, exp_bin = 0, exp_mag = 0;
   int   exp_valid = 0, exp_note = 0, exp_diff = 0;

   always #5 clk = ~clk;

   // One-cycle read latency: data follows the registered address within the next cycle.
   assign data_in = mem[mem_addr];

   fft_peak_tracker #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IM_OFFSET(IM_OFFSET), .BIN_LO(BIN_LO),
      .BIN_HI(BIN_HI), .BIN_W(BIN_W), .N_NOTES(N_NOTES), .MEM_LAT(MEM_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .mag_thresh(mag_thresh), .note_table(note_table), .data_in(data_in),
      .mem_addr(mem_addr), .busy(busy), .done(done), .valid(valid),
      .peak_bin(peak_bin), .peak_mag(peak_mag), .note(note), .difference(difference)
   );

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", busy, exp_busy);
         chk("done", done, exp_done);
         chk("peak_bin", peak_bin, exp_bin);
         chk("peak_mag", peak_mag, exp_mag);
         chk("valid", valid, exp_valid);
         chk("note", note, exp_note);
         chk("difference", $signed(difference), exp_diff);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      foreach (mem[i]) mem[i] = '0;
   endtask

   task automatic model(input int thr, output int pb, output int pm, output int v,
                        output int nt, output int df);
      int best, bd, re, im, m, e, d, ad;
      best = 0;
      pb   = BIN_LO;
      for (int b = BIN_LO; b <= BIN_HI; b++) begin
         re = $signed(mem[ADDR_W'(b)]);
         im = $signed(mem[ADDR_W'(b + IM_OFFSET)]);
         m  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
         if (m > best) begin best = m; pb = b; end
      end
      pm = best;
      v  = (best >= thr) ? 1 : 0;
      bd = 1 << 30;
      nt = 0;
      df = 0;
      for (int k = 0; k < N_NOTES; k++) begin
         e  = int'(note_table[k*BIN_W +: BIN_W]);
         d  = e - pb;
         ad = (d < 0) ? -d : d;
         if (ad < bd) begin bd = ad; nt = k; df = d; end
      end
      if (v == 0) begin nt = 0; df = 0; end
   endtask

   task automatic run_scan(input int thr);
      int pb, pm, v, nt, df;
      mag_thresh = (DATA_W+1)'(thr);
      model(thr, pb, pm, v, nt, df);
      start = 1'b1;
      tick();
      start    = 1'b0;
      exp_busy = 1;
      repeat (LAT - 1) tick();
      tick();
      exp_done = 1; exp_busy = 0;
      exp_bin = pb; exp_mag = pm; exp_valid = v; exp_note = nt; exp_diff = df;
      $display("scan thr=%0d -> bin=%0d mag=%0d valid=%0d note=%0d diff=%0d", thr, pb, pm, v, nt, df);
      tick();
      exp_done = 0;
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; abort = 1'b0; mag_thresh = '0;
      note_table = DEFAULT_NOTE_TABLE;
      clear_mem();
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b0;
      cmp_en = 1'b1;
      chk("reset_mem_addr", mem_addr, 0);

      // Single peak.
      mem[7] = 10'd100;
      mem[7 + IM_OFFSET] = 10'(-50);
      run_scan(10);
      chk("p1_bin", peak_bin, 7);
      chk("p1_mag", peak_mag, 150);
      chk("p1_valid", valid, 1);
      chk("p1_note", note, 1);
      chk("p1_diff", $signed(difference), 103);

      // Most negative samples, two equal peaks: first bin wins.
      clear_mem();
      mem[5] = 10'h200; mem[5 + IM_OFFSET] = 10'h200;
      mem[9] = 10'h200; mem[9 + IM_OFFSET] = 10'h200;
      run_scan(0);
      chk("ext_mag", peak_mag, 1024);
      chk("ext_bin", peak_bin, 5);

      // Threshold just above and exactly at the peak magnitude.
      clear_mem();
      mem[8] = 10'd20; mem[8 + IM_OFFSET] = 10'(-20);
      run_scan(41);
      chk("thr41_valid", valid, 0);
      chk("thr41_note", note, 0);
      chk("thr41_diff", $signed(difference), 0);
      run_scan(40);
      chk("thr40_valid", valid, 1);
      chk("thr40_diff", $signed(difference), 102);

      // Equidistant note entries and a nearer second entry.
      note_table = {10'd300, 10'd300, 10'd300, 10'd300, 10'd4, 10'd10};
      clear_mem();
      mem[7] = 10'd30;
      run_scan(1);
      chk("tie_note", note, 0);
      chk("tie_diff", $signed(difference), 3);
      clear_mem();
      mem[6] = 10'd30;
      run_scan(1);
      chk("near_note", note, 1);
      chk("near_diff", $signed(difference), -2);

      // All-zero memory.
      note_table = DEFAULT_NOTE_TABLE;
      clear_mem();
      run_scan(0);
      chk("zero_bin", peak_bin, BIN_LO);
      chk("zero_valid", valid, 1);

      // Abort twelve cycles into a scan; then abort+start together in IDLE.
      mem[10] = 10'd77;
      mag_thresh = 11'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_busy = 1;
      repeat (11) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_busy = 0;
      repeat (4) tick();
      $display("abort mid-scan, outputs held at bin=%0d", exp_bin);
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      chk("abort_start_busy", busy, 0);
      run_scan(5);
      chk("post_abort_bin", peak_bin, 10);

      // Async reset mid-RD_IM.
      clear_mem();
      mem[7] = 10'd100;
      mag_thresh = 11'd10;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_busy = 1;
      tick();
      #2;
      rst_n = 1'b1;
      #1;
      exp_busy = 0; exp_done = 0; exp_bin = 0; exp_mag = 0;
      exp_valid = 0; exp_note = 0; exp_diff = 0;
      chk("arst_busy", busy, 0);
      chk("arst_mag", peak_mag, 0);
      chk("arst_bin", peak_bin, 0);
      chk("arst_addr", mem_addr, 0);
      $display("async reset asserted mid-scan");
      start = 1'b1;
      repeat (2) tick();
      chk("rst_start_busy", busy, 0);
      rst_n = 1'b0;
      start = 1'b0;
      tick();
      run_scan(10);
      chk("recover_mag", peak_mag, 100);

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fft_peak_tracker.md
Name: fft_peak_tracker

Overview:
Parametrised successor of the single-peak frequency finder. Scans a configurable bin window of a split real/imag FFT result memory with configurable read latency, tracks the largest |re|+|im| bin, and gates the result against a runtime magnitude threshold. Matches the peak against a runtime-loadable note table of N_NOTES entries and reports the nearest note and its signed bin offset. Sits between the FFT result RAM and the tuner display/LED logic, with a start/busy/done handshake.

Parameters:
DATA_W, 10, signed width of FFT samples on data_in
ADDR_W, 11, memory address width
IM_OFFSET, 1024, address offset of the imaginary half (imag addr = bin + IM_OFFSET)
BIN_LO, 20, first bin scanned (inclusive)
BIN_HI, 511, last bin scanned (inclusive); BIN_LO <= BIN_HI < IM_OFFSET required
BIN_W, 10, width of bin indices and note-table entries (unsigned)
N_NOTES, 6, note-table entries
MEM_LAT, 2, clock edges from mem_addr update to valid data_in (>= 1)

Ports:
clk  in  1  sole clock
rst_n  in  1  asynchronous, active-high reset (asserted = 1; port name kept for consistency with the codebase)
start  in  1  begin scan; sampled only in IDLE
abort  in  1  cancel scan; returns to IDLE, no done
mag_thresh  in  DATA_W+1  minimum peak magnitude for a valid result
note_table  in  N_NOTES*BIN_W  packed bin positions; entry k = bits [k*BIN_W +: BIN_W]
data_in  in  DATA_W  signed memory read data
mem_addr  out  ADDR_W  memory read address (registered)
busy  out  1  high from start acceptance until done or abort
done  out  1  one-cycle pulse when results update
valid  out  1  peak_mag >= mag_thresh at the end of the scan
peak_bin  out  BIN_W  bin index of the largest magnitude
peak_mag  out  DATA_W+1  unsigned magnitude at peak_bin
note  out  $clog2(N_NOTES)  index of the nearest note-table entry
difference  out  BIN_W+1  signed note_table[note] - peak_bin

Behaviour:
- Reset (async): state IDLE; mem_addr=0, busy=0, done=0, valid=0, peak_bin=0, peak_mag=0, note=0, difference=0. Reset mid-scan discards everything.
- States: IDLE, RD_RE, RD_IM, CMP, NOTE, FIN.
- IDLE: start=1 -> mem_addr<=BIN_LO, bin<=BIN_LO, best_mag<=0, best_bin<=BIN_LO, busy<=1, wait counter cleared, go RD_RE. start while busy is ignored.
- RD_RE: MEM_LAT cycles. On the last cycle, capture re<=data_in and set mem_addr<=bin+IM_OFFSET; go RD_IM.
- RD_IM: MEM_LAT cycles. On the last cycle, capture im<=data_in; go CMP.
- CMP: 1 cycle. Compute mag=|re|+|im| with abs in DATA_W+1 bits, so -2^(DATA_W-1) maps exactly to 2^(DATA_W-1); mag never overflows (max 2^DATA_W). If mag > best_mag (strict; lowest bin wins ties), update best_mag and best_bin. If bin==BIN_HI go NOTE with k=0; else bin<=bin+1, mem_addr<=bin+1, go RD_RE.
- NOTE: 1 cycle per entry, k=0..N_NOTES-1. dist=|note_table[k]-best_bin| in BIN_W+1 signed bits. Strict < against the running minimum (initialised to all-ones); lowest k wins ties. After the last entry go FIN.
- FIN: outputs load together: peak_bin, peak_mag, valid=(best_mag>=mag_thresh), note, difference. If !valid, note=0 and difference=0. done=1 for this cycle, busy<=0, go IDLE.
- Per-bin cost is 2*MEM_LAT+1 cycles. Latency from the start-accept edge to the done pulse is NBINS*(2*MEM_LAT+1)+N_NOTES+1 cycles, where NBINS=BIN_HI-BIN_LO+1. At default parameters this is 2467.
- abort: in any non-IDLE state -> IDLE next edge, busy<=0, outputs keep their previous results, no done. abort has priority over start when both are asserted in IDLE (start ignored).
- Outputs hold between done pulses. note_table and mag_thresh are sampled during NOTE/FIN only.
- All-zero memory: peak_bin=BIN_LO, peak_mag=0, valid=1 only if mag_thresh=0.

Decomposition:
- Package fft_peak_pkg: state enum, DEFAULT_NOTE_TABLE = {165,110,147,196,247,330}, abs_ext function (sign-extend then negate).
- One sub-module, nearest_note: sequential table walk (k counter, running min, index), start/done internal handshake, parametrised by N_NOTES and BIN_W.

Test Plan:
- Bench params BIN_LO=4, BIN_HI=11, MEM_LAT=1, default table. Single peak: re[7]=100, im[7]=-50, all other bins 0, thresh=10 -> done exactly 31 cycles after start; peak_bin=7, peak_mag=150, valid=1, note=1 (110), difference=103.
- Extremes/tie: re[5]=-512, im[5]=-512, re[9]=-512, im[9]=-512 -> peak_mag=1024, peak_bin=5 (first wins).
- Threshold: max mag 40 with thresh=41 -> valid=0, note=0, difference=0; thresh=40 -> valid=1.
- Note tie: table entry 0=10, entry 1=4, others 300, peak at bin 7 -> note=0, difference=+3. Peak at bin 6 -> note=1, difference=-2.
- abort at cycle 12 of a scan -> busy falls next edge, no done, prior outputs unchanged; a new start then completes normally in 31 cycles.
- Async reset asserted mid-RD_IM between clock edges -> all outputs zero immediately; start ignored while reset is high.
